// File: rtl/pc_fetch.sv
// Instruction-fetch stage feeding PC_control: holds the architectural PC, fetches over a
// req/valid memory handshake, hands instructions to decode and halts on the HLT opcode.
module pc_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc_cur,
  input  logic [15:0] pc_next,
  output logic        pc_en,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic        flush,
  input  logic [15:0] flush_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    START,
    FETCH,
    ISSUE,
    HALT
  } state_t;

  state_t state;
  logic   drop;

  assign imem_req = (state == FETCH);
  assign pc_en    = (state == ISSUE) && dec_ready && !flush;

  // drop marks a request already in flight whose data belongs to a flushed path;
  // imem_addr never moves while a request is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= START;
      pc_cur      <= RESET_PC;
      imem_addr   <= RESET_PC;
      instr       <= 16'h0000;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      drop        <= 1'b0;
    end else begin
      case (state)
        START: begin
          imem_addr <= pc_cur;
          state     <= FETCH;
        end
        FETCH: begin
          if (imem_rvalid) begin
            if (flush) begin
              pc_cur    <= flush_pc;
              imem_addr <= flush_pc;
              drop      <= 1'b0;
            end else if (drop) begin
              drop      <= 1'b0;
              imem_addr <= pc_cur;
            end else begin
              instr <= imem_rdata;
              if (imem_rdata[15:12] == HALT_OP) begin
                halted <= 1'b1;
                state  <= HALT;
              end else begin
                instr_valid <= 1'b1;
                state       <= ISSUE;
              end
            end
          end else if (flush) begin
            pc_cur <= flush_pc;
            drop   <= 1'b1;
          end
        end
        ISSUE: begin
          if (flush) begin
            pc_cur      <= flush_pc;
            imem_addr   <= flush_pc;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end else if (dec_ready) begin
            pc_cur      <= pc_next;
            imem_addr   <= pc_next;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus randomized traffic, all checked every cycle
// against a transaction-level model of the fetch stage and its PC_control neighbour.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc_cur, pc_next, imem_addr, imem_rdata, instr, flush_pc;
  logic        pc_en, imem_req, imem_rvalid, instr_valid, dec_ready, flush, halted;
  logic        br;
  logic [8:0]  br_off;

  pc_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .pc_next(pc_next), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .dec_ready(dec_ready), .flush(flush), .flush_pc(flush_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // PC_control stand-in: sequential PC+2, or a PC-relative branch with a 9-bit word offset
  function automatic logic [15:0] pcTarget(input logic [15:0] pc, input logic b, input logic [8:0] off);
    return b ? pc + 16'd2 + {{6{off[8]}}, off, 1'b0} : pc + 16'd2;
  endfunction

  assign pc_next = pcTarget(pc_cur, br, br_off);

  logic [15:0] m_pc, m_addr, m_instr;
  logic        m_valid, m_drop, m_halted, m_started;
  int          n_vec = 0, n_fail = 0;
  int          lat_cfg, lat_cnt, cyc = 0;
  logic        halt_en, branch_at4;
  logic [15:0] halt_addr;
  logic [15:0] fetched[$];
  int          accepts[$];

  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 16'hF000;
    return {1'b0, a[14:0] ^ 15'h2A5C};
  endfunction

  function automatic int nextLat();
    return (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
  endfunction

  function automatic logic [15:0] fetchedAt(input int i);
    return (fetched.size() > i) ? fetched[i] : 16'hDEAD;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic compareAll(input logic dr, input logic fl);
    checkOutput("pc_cur", pc_cur, m_pc);
    checkOutput("imem_addr", imem_addr, m_addr);
    checkOutput("instr", instr, m_instr);
    checkOutput("instr_valid", 16'(instr_valid), 16'(m_valid));
    checkOutput("halted", 16'(halted), 16'(m_halted));
    checkOutput("imem_req", 16'(imem_req), 16'(m_started && !m_valid && !m_halted));
    checkOutput("pc_en", 16'(pc_en), 16'(m_valid && dr && !fl));
  endtask

  task automatic modelReset();
    m_pc = 16'h0000; m_addr = 16'h0000; m_instr = 16'h0000;
    m_valid = 1'b0; m_drop = 1'b0; m_halted = 1'b0; m_started = 1'b0;
  endtask

  // One clock of the fetch stage seen as transactions: waiting for data, holding an
  // instruction for decode, or halted.
  task automatic updateModel(input logic dr, input logic fl, input logic [15:0] fpc,
                             input logic b, input logic [8:0] off,
                             input logic rv, input logic [15:0] rd);
    if (!m_started) begin
      m_started = 1'b1;
      m_addr = m_pc;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_valid) begin
      if (fl) begin
        m_pc = fpc; m_addr = fpc; m_valid = 1'b0;
      end else if (dr) begin
        m_pc = pcTarget(m_pc, b, off); m_addr = m_pc; m_valid = 1'b0;
      end
    end else if (rv) begin
      if (fl) begin
        m_pc = fpc; m_addr = fpc; m_drop = 1'b0;
      end else if (m_drop) begin
        m_drop = 1'b0; m_addr = m_pc;
      end else begin
        m_instr = rd;
        if (rd[15:12] == 4'hF) m_halted = 1'b1;
        else m_valid = 1'b1;
      end
    end else if (fl) begin
      m_pc = fpc; m_drop = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic dr, input logic fl, input logic [15:0] fpc,
                               input logic b, input logic [8:0] off);
    @(negedge clk);
    dec_ready = dr; flush = fl; flush_pc = fpc; br = b; br_off = off;
    imem_rdata = 16'($urandom);
    if (imem_req) begin
      if (lat_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memWord(imem_addr);
        fetched.push_back(imem_addr);
        lat_cnt = nextLat();
      end else begin
        imem_rvalid = 1'b0;
        lat_cnt--;
      end
    end else begin
      imem_rvalid = 1'b0;
      lat_cnt = nextLat();
    end
    #1;
    compareAll(dr, fl);
    if (pc_en) accepts.push_back(cyc);
    updateModel(dr, fl, fpc, b, off, imem_rvalid, imem_rdata);
    cyc++;
  endtask

  task automatic step(input logic dr, input logic fl, input logic [15:0] fpc);
    applyStimulus(dr, fl, fpc, branch_at4 && (m_pc == 16'h0004), 9'h004);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; imem_rvalid = 1'b0; dec_ready = 1'b0; flush = 1'b0; br = 1'b0;
    #1;
    modelReset();
    compareAll(1'b0, 1'b0);
    checkOutput("reset_halted", 16'(halted), 16'h0000);
    checkOutput("reset_pc", pc_cur, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    lat_cnt = nextLat();
  endtask

  initial begin
    int n0;
    dec_ready = 1'b0; flush = 1'b0; flush_pc = 16'h0000; br = 1'b0; br_off = 9'h000;
    imem_rvalid = 1'b0; imem_rdata = 16'h0000;
    lat_cfg = 0; halt_en = 1'b0; halt_addr = 16'h0008; branch_at4 = 1'b1;
    modelReset();
    doReset();

    // sequential fetch with single-cycle memory, then a taken branch at 0004
    for (int i = 0; i < 40 && fetched.size() < 4; i++) step(1'b1, 1'b0, 16'h0000);
    checkOutput("fetch0", fetchedAt(0), 16'h0000);
    checkOutput("fetch1", fetchedAt(1), 16'h0002);
    checkOutput("fetch2", fetchedAt(2), 16'h0004);
    checkOutput("branch_fetch", fetchedAt(3), 16'h000E);
    checkOutput("pc_en_gap1", 16'((accepts.size() > 1) ? accepts[1] - accepts[0] : 0), 16'd2);
    checkOutput("pc_en_gap2", 16'((accepts.size() > 2) ? accepts[2] - accepts[1] : 0), 16'd2);
    branch_at4 = 1'b0;

    // decode stall
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0000);
    checkOutput("stall_pc", pc_cur, 16'h000E);
    checkOutput("stall_valid", 16'(instr_valid), 16'h0001);
    checkOutput("stall_instr", instr, 16'h2A52);

    // flush beats accept, then a second flush lands while 0010 is outstanding
    lat_cfg = 1;
    n0 = accepts.size();
    step(1'b1, 1'b1, 16'h0010);
    checkOutput("flush_no_accept", 16'(accepts.size() - n0), 16'h0000);
    step(1'b1, 1'b1, 16'h0040);
    checkOutput("flush_pc_applied", pc_cur, 16'h0010);
    checkOutput("outstanding_addr", imem_addr, 16'h0010);
    step(1'b1, 1'b0, 16'h0000);
    checkOutput("drop_addr_held", imem_addr, 16'h0010);
    checkOutput("drop_no_valid", 16'(instr_valid), 16'h0000);
    checkOutput("drop_pc", pc_cur, 16'h0040);
    for (int i = 0; i < 20 && !m_valid; i++) step(1'b1, 1'b0, 16'h0000);
    checkOutput("dropped_fetch", fetchedAt(4), 16'h0010);
    checkOutput("redirect_fetch", fetchedAt(5), 16'h0040);
    step(1'b0, 1'b0, 16'h0000);
    checkOutput("redirect_instr", instr, 16'h2A1C);

    // halt at 0008
    lat_cfg = 0; halt_en = 1'b1; halt_addr = 16'h0008;
    step(1'b1, 1'b1, 16'h0008);
    for (int i = 0; i < 20 && !m_halted; i++) step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    checkOutput("halt_flag", 16'(halted), 16'h0001);
    checkOutput("halt_pc", pc_cur, 16'h0008);
    checkOutput("halt_req", 16'(imem_req), 16'h0000);
    for (int i = 0; i < 6; i++) step(1'($urandom), 1'b1, 16'($urandom_range(0, 31) * 2));
    checkOutput("halt_flush_ignored", pc_cur, 16'h0008);
    doReset();

    // randomized traffic with variable memory latency
    lat_cfg = -1; halt_addr = 16'h0020;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                    16'($urandom_range(0, 31) * 2), $urandom_range(0, 3) == 0, 9'($urandom));
      if (m_halted && $urandom_range(0, 7) == 0) doReset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
